// File: rtl/rreq_rr_sequencer_if.sv
// Handshake bundle between N clocked requesters, the round-robin sequencer and the Rreq/Rack channel.
// slave is the sequencer's view; master is the requester/channel side.
interface rreq_rr_sequencer_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   go;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           Rreq;
  logic           Rack;
  logic           err;

  modport slave (
    input  go, Rack,
    output done, grant, grant_id, busy, Rreq, err
  );

  modport master (
    output go, Rack,
    input  done, grant, grant_id, busy, Rreq, err
  );
endinterface

// File: rtl/rreq_rr_sequencer.sv
// Round-robin sequencer: N level requesters share one four-phase Rreq/Rack channel, one handshake per grant.
// go->Rreq 1 cycle, Rack->reaction SYNC_STAGES+1 cycles; a stalled handshake is aborted and flagged in err.
module rreq_rr_sequencer #(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               rst,
  rreq_rr_sequencer_if.slave bus
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK_LO} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] primed;
  logic                   rack_s;
  logic                   sync_ok;
  logic [IDW-1:0]         ptr;
  logic [IDW-1:0]         pick;
  logic                   pick_vld;
  logic [IDW:0]           idx;
  logic [IDW-1:0]         next_ptr;
  logic [CW-1:0]          cnt;
  logic                   expired;
  logic                   finish;

  logic [N-1:0]           done;
  logic [N-1:0]           grant;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic                   rreq;
  logic                   err;

  assign rack_s   = sync[SYNC_STAGES-1];
  // Right after reset the synchroniser still holds cleared flops, not real Rack
  // samples; granting is held off until it has refilled so a stale ack is seen.
  assign sync_ok  = primed[SYNC_STAGES-1];
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign expired  = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign finish   = expired || ((state == ACK_LO) && !rack_s);

  // First set go at or after ptr, wrapping modulo N.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDW + 1)'(k);
      if (idx >= (IDW + 1)'(N)) idx = idx - (IDW + 1)'(N);
      if (bus.go[idx[IDW-1:0]]) begin
        pick     = idx[IDW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sync     <= '0;
      primed   <= '0;
      ptr      <= '0;
      cnt      <= '0;
      done     <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      rreq     <= 1'b0;
      err      <= 1'b0;
    end else begin
      sync   <= SYNC_STAGES'({sync, bus.Rack});
      primed <= SYNC_STAGES'({primed, 1'b1});
      done   <= '0;
      case (state)
        IDLE: begin
          if (sync_ok && !rack_s && pick_vld) begin
            state    <= REQ;
            grant    <= N'(1) << pick;
            grant_id <= pick;
            busy     <= 1'b1;
            rreq     <= 1'b1;
            cnt      <= '0;
          end
        end
        REQ, ACK_LO: begin
          cnt <= cnt + 1'b1;
          // Watchdog expiry wins over a completing ack in the same cycle.
          if (finish) begin
            done     <= expired ? '0 : grant;
            err      <= err | expired;
            ptr      <= next_ptr;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            rreq     <= 1'b0;
            state    <= IDLE;
          end else if ((state == REQ) && rack_s) begin
            rreq  <= 1'b0;
            state <= ACK_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done     = done;
  assign bus.grant    = grant;
  assign bus.grant_id = grant_id;
  assign bus.busy     = busy;
  assign bus.Rreq     = rreq;
  assign bus.err      = err;
endmodule
